// File: rtl/dma_axi_wr_master_if.sv
// Request, buffer and AXI write-channel bundle of the DMA write engine.
// The master modport is the engine's view; slave is the surrounding system.
interface dma_axi_wr_master_if #(
    parameter int DMA_ADDR_WIDTH = 32,
    parameter int DMA_DATA_WIDTH = 64,
    parameter int AXI_STRB_WIDTH = DMA_DATA_WIDTH / 8
);
    logic                      dma_axi_req_valid;
    logic [DMA_ADDR_WIDTH-1:0] dma_axi_req_addr;
    logic [AXI_STRB_WIDTH-1:0] dma_axi_req_strb;
    logic [2:0]                dma_axi_req_size;
    logic [7:0]                dma_axi_req_alen;
    logic                      dma_axi_resp_ready;

    logic [DMA_DATA_WIDTH-1:0] buf_rdata;
    logic                      buf_rvalid;
    logic                      buf_rready;

    logic                      m_awvalid;
    logic                      m_awready;
    logic [DMA_ADDR_WIDTH-1:0] m_awaddr;
    logic [7:0]                m_awlen;
    logic [2:0]                m_awsize;
    logic [1:0]                m_awburst;

    logic                      m_wvalid;
    logic                      m_wready;
    logic [DMA_DATA_WIDTH-1:0] m_wdata;
    logic [AXI_STRB_WIDTH-1:0] m_wstrb;
    logic                      m_wlast;

    logic                      m_bvalid;
    logic [1:0]                m_bresp;
    logic                      m_bready;

    modport master (
        input  dma_axi_req_valid, dma_axi_req_addr, dma_axi_req_strb,
        input  dma_axi_req_size, dma_axi_req_alen,
        output dma_axi_resp_ready,
        input  buf_rdata, buf_rvalid,
        output buf_rready,
        output m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst,
        input  m_awready,
        output m_wvalid, m_wdata, m_wstrb, m_wlast,
        input  m_wready,
        input  m_bvalid, m_bresp,
        output m_bready
    );

    modport slave (
        output dma_axi_req_valid, dma_axi_req_addr, dma_axi_req_strb,
        output dma_axi_req_size, dma_axi_req_alen,
        input  dma_axi_resp_ready,
        output buf_rdata, buf_rvalid,
        input  buf_rready,
        input  m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst,
        output m_awready,
        input  m_wvalid, m_wdata, m_wstrb, m_wlast,
        output m_wready,
        output m_bvalid, m_bresp,
        input  m_bready
    );
endinterface

// File: rtl/dma_axi_wr_master.sv
// AXI4 write engine: takes one DMA request, issues its AW burst, streams W
// beats from the data buffer and counts outstanding B responses.
module dma_axi_wr_master #(
    parameter int DMA_ADDR_WIDTH  = 32,
    parameter int DMA_DATA_WIDTH  = 64,
    parameter int AXI_STRB_WIDTH  = DMA_DATA_WIDTH / 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int OST_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    dma_axi_wr_master_if.master         bus,
    input  logic                        wr_err_clr,
    output logic                        wr_err,
    output logic                        wr_idle
);

    if (DMA_DATA_WIDTH != 32 && DMA_DATA_WIDTH != 64) begin : g_bad_data_width
        $error("dma_axi_wr_master: DMA_DATA_WIDTH must be 32 or 64");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_bad_max_ost
        $error("dma_axi_wr_master: MAX_OUTSTANDING must be 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AW   = 2'd1,
        S_W    = 2'd2
    } state_e;

    localparam logic [OST_WIDTH-1:0] OST_MAX = OST_WIDTH'(MAX_OUTSTANDING);
    localparam logic [OST_WIDTH-1:0] OST_ONE = OST_WIDTH'(1);

    state_e                    state_q, state_d;
    logic [OST_WIDTH-1:0]      ost_cnt_q, ost_cnt_d;
    logic [7:0]                beat_cnt_q, beat_cnt_d;
    logic [DMA_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AXI_STRB_WIDTH-1:0] strb_q, strb_d;
    logic [2:0]                size_q, size_d;
    logic [7:0]                alen_q, alen_d;
    logic                      wr_err_q, wr_err_d;

    logic req_ready;
    logic req_accept;
    logic aw_hs;
    logic w_hs;
    logic beat_is_last;
    logic b_hs;
    logic b_stray;
    logic unused_bresp0;

    // Handshake decode; ready depends on registers only, never on req_valid.
    assign req_ready     = (state_q == S_IDLE) && (ost_cnt_q < OST_MAX);
    assign req_accept    = req_ready && bus.dma_axi_req_valid;
    assign aw_hs         = (state_q == S_AW) && bus.m_awready;
    assign w_hs          = (state_q == S_W) && bus.buf_rvalid && bus.m_wready;
    assign beat_is_last  = (beat_cnt_q == alen_q);
    assign b_hs          = bus.m_bvalid;
    assign b_stray       = b_hs && (ost_cnt_q == '0);
    assign unused_bresp0 = bus.m_bresp[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (req_accept)           state_d = S_AW;
            S_AW:   if (aw_hs)                state_d = S_W;
            S_W:    if (w_hs && beat_is_last) state_d = S_IDLE;
            default:                          state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.dma_axi_resp_ready = req_ready;
        bus.m_awvalid          = (state_q == S_AW);
        bus.m_awaddr           = addr_q;
        bus.m_awlen            = alen_q;
        bus.m_awsize           = size_q;
        bus.m_awburst          = 2'b01;
        bus.m_wvalid           = (state_q == S_W) && bus.buf_rvalid;
        bus.buf_rready         = (state_q == S_W) && bus.m_wready;
        bus.m_wdata            = bus.buf_rdata;
        bus.m_wstrb            = strb_q;
        bus.m_wlast            = (state_q == S_W) && beat_is_last;
        bus.m_bready           = 1'b1;
        wr_err                 = wr_err_q;
        wr_idle                = (state_q == S_IDLE) && (ost_cnt_q == '0);
    end

    // A stray B at zero outstanding must not underflow the counter; an error
    // set in the same cycle as a clear request takes priority.
    always_comb begin
        addr_d     = addr_q;
        strb_d     = strb_q;
        size_d     = size_q;
        alen_d     = alen_q;
        beat_cnt_d = beat_cnt_q;
        ost_cnt_d  = ost_cnt_q;
        wr_err_d   = wr_err_q;

        if (req_accept) begin
            addr_d     = bus.dma_axi_req_addr;
            strb_d     = bus.dma_axi_req_strb;
            size_d     = bus.dma_axi_req_size;
            alen_d     = bus.dma_axi_req_alen;
            beat_cnt_d = '0;
        end else if (w_hs) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
        end

        unique case ({req_accept, b_hs && !b_stray})
            2'b10:   ost_cnt_d = ost_cnt_q + OST_ONE;
            2'b01:   ost_cnt_d = ost_cnt_q - OST_ONE;
            default: ost_cnt_d = ost_cnt_q;
        endcase

        if (b_hs && (bus.m_bresp[1] || b_stray)) begin
            wr_err_d = 1'b1;
        end else if (wr_err_clr) begin
            wr_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ost_cnt_q  <= '0;
            beat_cnt_q <= '0;
            addr_q     <= '0;
            strb_q     <= '0;
            size_q     <= '0;
            alen_q     <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            ost_cnt_q  <= ost_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            addr_q     <= addr_d;
            strb_q     <= strb_d;
            size_q     <= size_d;
            alen_q     <= alen_d;
            wr_err_q   <= wr_err_d;
        end
    end

endmodule

// File: tb/tb_dma_axi_wr_master.sv
// Scoreboard bench for dma_axi_wr_master: expected AW/W traffic is queued as
// requests are issued and popped by monitors on each channel handshake.
module tb_dma_axi_wr_master;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } aw_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } w_t;

    logic clk;
    logic rst_n;
    logic wr_err_clr;
    logic wr_err;
    logic wr_idle;

    int total = 0;
    int bad   = 0;

    aw_t         exp_aw[$];
    w_t          exp_w[$];
    logic [63:0] bq[$];
    aw_t         mon_aw;
    w_t          mon_w;
    logic        pop_next;

    dma_axi_wr_master_if #(.DMA_ADDR_WIDTH(32), .DMA_DATA_WIDTH(64)) bus ();

    dma_axi_wr_master #(
        .DMA_ADDR_WIDTH (32),
        .DMA_DATA_WIDTH (64),
        .MAX_OUTSTANDING(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .wr_err_clr(wr_err_clr),
        .wr_err    (wr_err),
        .wr_idle   (wr_idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got unexpected event expected none", name);
    endtask

    // Monitors: every channel handshake must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n && bus.m_awvalid && bus.m_awready) begin
            if (exp_aw.size() == 0) begin
                failNow("aw_unexpected");
            end else begin
                mon_aw = exp_aw.pop_front();
                checkOutput("aw_payload", {bus.m_awaddr, bus.m_awlen, bus.m_awsize, bus.m_awburst}, mon_aw);
            end
        end
        if (rst_n && bus.m_wvalid && bus.m_wready) begin
            if (exp_w.size() == 0) begin
                failNow("w_unexpected");
            end else begin
                mon_w = exp_w.pop_front();
                checkOutput("w_beat", {bus.m_wdata, bus.m_wstrb, bus.m_wlast}, mon_w);
            end
        end
    end

    // Data buffer model: head of bq is presented, popped on rvalid & rready.
    initial begin
        bus.buf_rvalid = 1'b0;
        bus.buf_rdata  = '0;
        forever begin
            @(negedge clk);
            pop_next = bus.buf_rvalid && bus.buf_rready;
            @(posedge clk);
            #1;
            if (pop_next && bq.size() > 0) bq.delete(0);
            if (bq.size() > 0) begin
                bus.buf_rvalid = 1'b1;
                bus.buf_rdata  = bq[0];
            end else begin
                bus.buf_rvalid = 1'b0;
                bus.buf_rdata  = '0;
            end
        end
    end

    task automatic pushBeat(input logic [63:0] data, input logic [7:0] strb, input logic last);
        bq.push_back(data);
        exp_w.push_back({data, strb, last});
    endtask

    task automatic setReq(input logic [31:0] addr, input logic [7:0] strb, input logic [2:0] size, input logic [7:0] alen);
        bus.dma_axi_req_addr = addr;
        bus.dma_axi_req_strb = strb;
        bus.dma_axi_req_size = size;
        bus.dma_axi_req_alen = alen;
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] strb, input logic [2:0] size, input logic [7:0] alen);
        bit ok = 0;
        exp_aw.push_back({addr, alen, size, 2'b01});
        @(posedge clk);
        #1;
        setReq(addr, strb, size, alen);
        bus.dma_axi_req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.dma_axi_resp_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        bus.dma_axi_req_valid = 1'b0;
        checkOutput("req_accepted", ok, 1'b1);
    endtask

    task automatic sendB(input logic [1:0] resp, input logic clr);
        @(posedge clk);
        #1;
        bus.m_bvalid = 1'b1;
        bus.m_bresp  = resp;
        wr_err_clr   = clr;
        @(posedge clk);
        #1;
        bus.m_bvalid = 1'b0;
        bus.m_bresp  = 2'b00;
        wr_err_clr   = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulseClr();
        @(posedge clk);
        #1;
        wr_err_clr = 1'b1;
        @(posedge clk);
        #1;
        wr_err_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while ((exp_aw.size() != 0 || exp_w.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_aw.size() != 0 || exp_w.size() != 0) failNow({name, "_drain_timeout"});
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_awvalid"},    bus.m_awvalid, 1'b0);
        checkOutput({tag, "_wvalid"},     bus.m_wvalid, 1'b0);
        checkOutput({tag, "_buf_rready"}, bus.buf_rready, 1'b0);
        checkOutput({tag, "_wlast"},      bus.m_wlast, 1'b0);
        checkOutput({tag, "_awaddr"},     bus.m_awaddr, 32'h0);
        checkOutput({tag, "_awlen"},      bus.m_awlen, 8'h0);
        checkOutput({tag, "_awsize"},     bus.m_awsize, 3'h0);
        checkOutput({tag, "_wstrb"},      bus.m_wstrb, 8'h0);
        checkOutput({tag, "_awburst"},    bus.m_awburst, 2'b01);
        checkOutput({tag, "_bready"},     bus.m_bready, 1'b1);
        checkOutput({tag, "_wr_err"},     wr_err, 1'b0);
        checkOutput({tag, "_wr_idle"},    wr_idle, 1'b1);
        checkOutput({tag, "_resp_ready"}, bus.dma_axi_resp_ready, 1'b1);
    endtask

    // Burst with m_wready dropped for two cycles ahead of beats 3 and 5.
    task automatic runBurstStalls(output int done);
        int  low_left = 0;
        bit  s3 = 0;
        bit  s5 = 0;
        done = 0;
        for (int cyc = 0; cyc < 200 && done < 8; cyc++) begin
            @(negedge clk);
            if (bus.m_wvalid && bus.m_wready) done++;
            @(posedge clk);
            #1;
            if (low_left > 0) low_left--;
            if (done == 2 && !s3) begin s3 = 1; low_left = 2; end
            if (done == 4 && !s5) begin s5 = 1; low_left = 2; end
            bus.m_wready = (low_left == 0);
        end
    endtask

    initial begin
        #400000;
        failNow("global_timeout");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int done;
        rst_n                 = 1'b0;
        wr_err_clr            = 1'b0;
        bus.dma_axi_req_valid = 1'b0;
        setReq('0, '0, '0, '0);
        bus.m_awready         = 1'b0;
        bus.m_wready          = 1'b0;
        bus.m_bvalid          = 1'b0;
        bus.m_bresp           = 2'b00;

        repeat (2) @(negedge clk);
        checkResetValues("por");
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.m_awready = 1'b1;
        bus.m_wready  = 1'b1;

        $display("[TB] single beat");
        pushBeat(64'hA5A5_0000_5A5A_FFFF, 8'hF0, 1'b1);
        applyStimulus(32'h1004, 8'hF0, 3'd3, 8'd0);
        @(negedge clk);
        checkOutput("t1_ready_T1", bus.dma_axi_resp_ready, 1'b0);
        checkOutput("t1_awvalid_T1", bus.m_awvalid, 1'b1);
        @(negedge clk);
        checkOutput("t1_ready_T2", bus.dma_axi_resp_ready, 1'b0);
        checkOutput("t1_wvalid_T2", bus.m_wvalid, 1'b1);
        @(negedge clk);
        checkOutput("t1_ready_T3", bus.dma_axi_resp_ready, 1'b1);
        checkOutput("t1_idle_T3", wr_idle, 1'b0);
        sendB(2'b00, 1'b0);
        checkOutput("t1_idle_after_b", wr_idle, 1'b1);

        $display("[TB] burst with W stalls");
        for (int i = 1; i <= 8; i++) pushBeat(64'(i), 8'hFF, (i == 8));
        applyStimulus(32'h2000, 8'hFF, 3'd3, 8'd7);
        runBurstStalls(done);
        checkOutput("t2_beats", 32'(done), 32'd8);
        checkOutput("t2_wq_empty", 32'(exp_w.size()), 32'd0);
        sendB(2'b00, 1'b0);
        checkOutput("t2_idle", wr_idle, 1'b1);

        $display("[TB] outstanding limit");
        for (int i = 0; i < 4; i++) begin
            pushBeat(64'h4400 + 64'(i), 8'hFF, 1'b1);
            applyStimulus(32'h4000 + 32'(8 * i), 8'hFF, 3'd3, 8'd0);
        end
        waitDrain("t3");
        exp_aw.push_back({32'h4020, 8'd0, 3'd3, 2'b01});
        pushBeat(64'h4404, 8'hFF, 1'b1);
        @(posedge clk);
        #1;
        setReq(32'h4020, 8'hFF, 3'd3, 8'd0);
        bus.dma_axi_req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("t3_ready_held_low", bus.dma_axi_resp_ready, 1'b0);
            checkOutput("t3_not_idle", wr_idle, 1'b0);
            @(posedge clk);
            #1;
        end
        bus.m_bvalid = 1'b1;
        @(negedge clk);
        checkOutput("t3_ready_during_b", bus.dma_axi_resp_ready, 1'b0);
        @(posedge clk);
        #1;
        bus.m_bvalid = 1'b0;
        @(negedge clk);
        checkOutput("t3_ready_after_b", bus.dma_axi_resp_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.dma_axi_req_valid = 1'b0;
        @(negedge clk);
        checkOutput("t3_ready_full_again", bus.dma_axi_resp_ready, 1'b0);
        checkOutput("t3_not_idle_end", wr_idle, 1'b0);
        waitDrain("t3b");

        $display("[TB] accept and B in the same cycle");
        sendB(2'b00, 1'b0);
        sendB(2'b00, 1'b0);
        exp_aw.push_back({32'h5000, 8'd0, 3'd3, 2'b01});
        pushBeat(64'h5555, 8'h3C, 1'b1);
        @(posedge clk);
        #1;
        setReq(32'h5000, 8'h3C, 3'd3, 8'd0);
        bus.dma_axi_req_valid = 1'b1;
        bus.m_bvalid          = 1'b1;
        @(negedge clk);
        checkOutput("t4_ready_at_ost2", bus.dma_axi_resp_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.dma_axi_req_valid = 1'b0;
        bus.m_bvalid          = 1'b0;
        waitDrain("t4");
        sendB(2'b00, 1'b0);
        checkOutput("t4_not_idle_ost1", wr_idle, 1'b0);
        sendB(2'b00, 1'b0);
        checkOutput("t4_idle_ost0", wr_idle, 1'b1);
        checkOutput("t4_no_err", wr_err, 1'b0);

        $display("[TB] error handling");
        pushBeat(64'h6666, 8'hFF, 1'b1);
        applyStimulus(32'h6000, 8'hFF, 3'd3, 8'd0);
        waitDrain("t5");
        sendB(2'b10, 1'b0);
        checkOutput("t5_slverr_set", wr_err, 1'b1);
        checkOutput("t5_idle_after_err", wr_idle, 1'b1);
        pulseClr();
        checkOutput("t5_cleared", wr_err, 1'b0);
        pulseClr();
        checkOutput("t5_clr_no_err", wr_err, 1'b0);
        sendB(2'b00, 1'b0);
        checkOutput("t5_stray_set", wr_err, 1'b1);
        checkOutput("t5_stray_idle", wr_idle, 1'b1);
        pulseClr();
        pushBeat(64'h7777, 8'hFF, 1'b1);
        applyStimulus(32'h6100, 8'hFF, 3'd3, 8'd0);
        waitDrain("t5b");
        repeat (2) @(negedge clk);
        checkOutput("t5_ost1_not_idle", wr_idle, 1'b0);
        checkOutput("t5_ost1_ready", bus.dma_axi_resp_ready, 1'b1);
        sendB(2'b11, 1'b1);
        checkOutput("t5_set_beats_clr", wr_err, 1'b1);
        checkOutput("t5_idle_final", wr_idle, 1'b1);
        pulseClr();
        checkOutput("t5_err_final", wr_err, 1'b0);

        $display("[TB] reset mid-burst");
        for (int i = 1; i <= 8; i++) pushBeat(64'h100 + 64'(i), 8'hFF, (i == 8));
        applyStimulus(32'h7000, 8'hFF, 3'd3, 8'd7);
        done = 0;
        for (int cyc = 0; cyc < 50 && done < 2; cyc++) begin
            @(negedge clk);
            if (bus.m_wvalid && bus.m_wready) done++;
        end
        checkOutput("t6_two_beats", 32'(done), 32'd2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checkResetValues("mid");
        exp_w.delete();
        bq.delete();
        repeat (2) @(negedge clk);
        checkOutput("mid_hold_awvalid", bus.m_awvalid, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pushBeat(64'hDEAD_BEEF_0000_0001, 8'h0F, 1'b0);
        pushBeat(64'hDEAD_BEEF_0000_0002, 8'h0F, 1'b1);
        applyStimulus(32'h8000, 8'h0F, 3'd3, 8'd1);
        waitDrain("t6");
        sendB(2'b00, 1'b0);
        checkOutput("t6_idle", wr_idle, 1'b1);
        checkOutput("t6_err", wr_err, 1'b0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
